// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with flush-to-bubble, forwarding compare and a
// request/acknowledge wait-state FSM that holds memory accesses until acknowledged.
module ex_mem_stage #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int NUM_RD   = 2,
    parameter int HOLD_LVL = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                hold_flag_i,
    input  logic                      flush_i,
    input  logic                      ex_valid_i,
    input  logic [DATA_W-1:0]         reg_wdata_i,
    input  logic                      reg_we_i,
    input  logic [RADDR_W-1:0]        reg_waddr_i,
    input  logic                      mem_req_i,
    input  logic                      mem_we_i,
    input  logic [DATA_W-1:0]         mem_addr_i,
    input  logic [DATA_W-1:0]         mem_wdata_i,
    input  logic                      jump_flag_i,
    input  logic [DATA_W-1:0]         jump_addr_i,
    input  logic [NUM_RD*RADDR_W-1:0] id_raddr_i,
    input  logic                      mem_ack_i,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic                      valid_o,
    output logic [DATA_W-1:0]         reg_wdata_o,
    output logic                      reg_we_o,
    output logic [RADDR_W-1:0]        reg_waddr_o,
    output logic                      jump_flag_o,
    output logic [DATA_W-1:0]         jump_addr_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [DATA_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    output logic [NUM_RD-1:0]         fwd_flag_o,
    output logic [DATA_W-1:0]         fwd_data_o,
    output logic                      hold_req_o
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    logic [0:0]         state_p1;
    logic               valid_p1;
    logic               reg_we_p1;
    logic               jump_flag_p1;
    logic               mem_we_p1;
    logic [DATA_W-1:0]  reg_wdata_p1;
    logic [DATA_W-1:0]  jump_addr_p1;
    logic [DATA_W-1:0]  mem_addr_p1;
    logic [DATA_W-1:0]  mem_wdata_p1;
    logic [RADDR_W-1:0] reg_waddr_p1;

    logic mem_wait;
    logic freeze;
    logic load_pending;

    assign mem_wait     = (state_p1 == ST_MEM_WAIT);
    assign freeze       = (hold_flag_i >= 3'(HOLD_LVL)) || mem_wait;
    assign load_pending = mem_wait && !mem_we_p1;

    // EX -> MEM boundary: capture, bubble, or freeze (ack may still land load data)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_p1     <= ST_IDLE;
            valid_p1     <= 1'b0;
            reg_we_p1    <= 1'b0;
            jump_flag_p1 <= 1'b0;
            mem_we_p1    <= 1'b0;
            reg_wdata_p1 <= '0;
            jump_addr_p1 <= '0;
            mem_addr_p1  <= '0;
            mem_wdata_p1 <= '0;
            reg_waddr_p1 <= '0;
        end else if (freeze) begin
            if (mem_wait && mem_ack_i) begin
                state_p1 <= ST_IDLE;
                if (!mem_we_p1) begin
                    reg_wdata_p1 <= mem_rdata_i;
                end
            end
        end else if (flush_i) begin
            state_p1     <= ST_IDLE;
            valid_p1     <= 1'b0;
            reg_we_p1    <= 1'b0;
            jump_flag_p1 <= 1'b0;
            mem_we_p1    <= 1'b0;
            reg_wdata_p1 <= '0;
            jump_addr_p1 <= '0;
            mem_addr_p1  <= '0;
            mem_wdata_p1 <= '0;
            reg_waddr_p1 <= '0;
        end else begin
            state_p1     <= (ex_valid_i && mem_req_i) ? ST_MEM_WAIT : ST_IDLE;
            valid_p1     <= ex_valid_i;
            reg_we_p1    <= ex_valid_i && reg_we_i;
            jump_flag_p1 <= ex_valid_i && jump_flag_i;
            mem_we_p1    <= mem_we_i;
            reg_wdata_p1 <= reg_wdata_i;
            jump_addr_p1 <= jump_addr_i;
            mem_addr_p1  <= mem_addr_i;
            mem_wdata_p1 <= mem_wdata_i;
            reg_waddr_p1 <= reg_waddr_i;
        end
    end

    // Forwarding from registered state; x0 and a load still in flight never forward
    always_comb begin
        fwd_flag_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            fwd_flag_o[k] = valid_p1 && reg_we_p1 && (reg_waddr_p1 != '0) &&
                            (reg_waddr_p1 == id_raddr_i[k*RADDR_W +: RADDR_W]) &&
                            !load_pending;
        end
    end

    assign valid_o     = valid_p1;
    assign reg_wdata_o = reg_wdata_p1;
    assign reg_we_o    = reg_we_p1;
    assign reg_waddr_o = reg_waddr_p1;
    assign jump_flag_o = jump_flag_p1;
    assign jump_addr_o = jump_addr_p1;
    assign mem_req_o   = mem_wait;
    assign mem_we_o    = mem_we_p1;
    assign mem_addr_o  = mem_addr_p1;
    assign mem_wdata_o = mem_wdata_p1;
    assign fwd_data_o  = reg_wdata_p1;
    assign hold_req_o  = mem_wait;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized
// cycles checked against a behavioural model of the stage.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int VW = 1 + DW + 1 + AW + 1 + DW + 1 + 1 + DW + DW + NR + DW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    hold_flag;
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] reg_wdata;
    logic          reg_we;
    logic [AW-1:0] reg_waddr;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          jump_flag;
    logic [DW-1:0] jump_addr;
    logic [NR*AW-1:0] id_raddr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          valid_o, reg_we_o, jump_flag_o, mem_req_o, mem_we_o, hold_req_o;
    logic [DW-1:0] reg_wdata_o, jump_addr_o, mem_addr_o, mem_wdata_o, fwd_data_o;
    logic [AW-1:0] reg_waddr_o;
    logic [NR-1:0] fwd_flag_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model of what the stage should be holding
    logic          m_valid = 0, m_we = 0, m_jf = 0, m_mwe = 0, m_busy = 0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0, m_ja = '0, m_maddr = '0, m_mwdata = '0;

    ex_mem_stage #(.DATA_W(DW), .RADDR_W(AW), .NUM_RD(NR), .HOLD_LVL(3)) dut (
        .clk(clk), .rst(rst), .hold_flag_i(hold_flag), .flush_i(flush),
        .ex_valid_i(ex_valid), .reg_wdata_i(reg_wdata), .reg_we_i(reg_we),
        .reg_waddr_i(reg_waddr), .mem_req_i(mem_req), .mem_we_i(mem_we),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .jump_flag_i(jump_flag),
        .jump_addr_i(jump_addr), .id_raddr_i(id_raddr), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .valid_o(valid_o), .reg_wdata_o(reg_wdata_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .jump_flag_o(jump_flag_o),
        .jump_addr_o(jump_addr_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .fwd_flag_o(fwd_flag_o),
        .fwd_data_o(fwd_data_o), .hold_req_o(hold_req_o)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] dut_vec();
        return {valid_o, reg_wdata_o, reg_we_o, reg_waddr_o, jump_flag_o, jump_addr_o,
                mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, fwd_flag_o, fwd_data_o,
                hold_req_o};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [NR-1:0] f;
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] ra;
            ra = id_raddr[k*AW +: AW];
            f[k] = m_valid && m_we && (m_waddr != 0) && (m_waddr == ra) && !(m_busy && !m_mwe);
        end
        return {m_valid, m_wdata, m_we, m_waddr, m_jf, m_ja, m_busy, m_mwe, m_maddr,
                m_mwdata, f, m_wdata, m_busy};
    endfunction

    // what the stage should do at a clock edge given the current inputs
    task automatic model_edge();
        if (!rst) begin
            {m_valid, m_we, m_jf, m_mwe, m_busy} = '0;
            m_waddr = '0; m_wdata = '0; m_ja = '0; m_maddr = '0; m_mwdata = '0;
        end else if (m_busy || hold_flag >= 3) begin
            if (m_busy && mem_ack) begin
                m_busy = 1'b0;
                if (!m_mwe) m_wdata = mem_rdata;
            end
        end else if (flush) begin
            {m_valid, m_we, m_jf, m_mwe, m_busy} = '0;
            m_waddr = '0; m_wdata = '0; m_ja = '0; m_maddr = '0; m_mwdata = '0;
        end else begin
            m_valid = ex_valid;
            m_we    = ex_valid & reg_we;
            m_jf    = ex_valid & jump_flag;
            m_busy  = ex_valid & mem_req;
            m_mwe   = mem_we;
            m_waddr = reg_waddr;
            m_wdata = reg_wdata;
            m_ja    = jump_addr;
            m_maddr = mem_addr;
            m_mwdata = mem_wdata;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        hold_flag = 0; flush = 0; ex_valid = 0; reg_wdata = 0; reg_we = 0;
        reg_waddr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
        jump_flag = 0; jump_addr = 0; id_raddr = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 0;
        ex_valid = 1; reg_we = 1; reg_waddr = 5'd3; reg_wdata = 32'hFFFF_0000;
        mem_req = 1; jump_flag = 1; jump_addr = 32'h40; id_raddr = {5'd3, 5'd3};
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (dut_vec() !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h want 0", i, dut_vec());
            end
        end
        rst = 1;
        drive_idle();
        ex_valid = 1; reg_we = 1; reg_waddr = 5'd5; reg_wdata = 32'h1234;
        tick();
        n_cmp++;
        if ({valid_o, reg_we_o, reg_waddr_o, reg_wdata_o, mem_req_o} !== {1'b1, 1'b1, 5'd5, 32'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_capture: got v=%b we=%b wa=%0d wd=%h req=%b want 1 1 5 00001234 0",
                     valid_o, reg_we_o, reg_waddr_o, reg_wdata_o, mem_req_o);
        end
    endtask

    task automatic test_forward();
        id_raddr = {5'd0, 5'd5};
        #1;
        n_cmp++;
        if (fwd_flag_o !== 2'b01 || fwd_data_o !== 32'h1234) begin
            n_fail++;
            $display("FAIL fwd_hit: got flag=%b data=%h want 01 00001234", fwd_flag_o, fwd_data_o);
        end
        ex_valid = 1; reg_we = 1; reg_waddr = 5'd0; reg_wdata = 32'h99;
        tick();
        id_raddr = {5'd0, 5'd0};
        #1;
        n_cmp++;
        if (fwd_flag_o !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_x0: got %b want 00", fwd_flag_o);
        end
        reg_we = 0; reg_waddr = 5'd5;
        tick();
        id_raddr = {5'd5, 5'd5};
        #1;
        n_cmp++;
        if (fwd_flag_o !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_no_we: got %b want 00", fwd_flag_o);
        end
    endtask

    task automatic test_load();
        drive_idle();
        ex_valid = 1; reg_we = 1; reg_waddr = 5'd7; mem_req = 1; mem_we = 0;
        mem_addr = 32'h100; id_raddr = {5'd7, 5'd7};
        tick();
        ex_valid = 1; reg_we = 1; reg_waddr = 5'd9; reg_wdata = 32'h55; mem_req = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({mem_req_o, hold_req_o, fwd_flag_o, mem_addr_o} !== {1'b1, 1'b1, 2'b00, 32'h100}) begin
                n_fail++;
                $display("FAIL load_wait cycle %0d: got req=%b hold=%b fwd=%b addr=%h want 1 1 00 00000100",
                         i, mem_req_o, hold_req_o, fwd_flag_o, mem_addr_o);
            end
            if (i == 2) begin
                mem_ack = 1; mem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        mem_ack = 0; mem_rdata = 0;
        n_cmp++;
        if ({mem_req_o, hold_req_o, reg_wdata_o, reg_waddr_o, fwd_flag_o} !==
            {1'b0, 1'b0, 32'hDEADBEEF, 5'd7, 2'b11}) begin
            n_fail++;
            $display("FAIL load_done: got req=%b hold=%b wd=%h wa=%0d fwd=%b want 0 0 deadbeef 7 11",
                     mem_req_o, hold_req_o, reg_wdata_o, reg_waddr_o, fwd_flag_o);
        end
        tick();
        n_cmp++;
        if ({reg_waddr_o, reg_wdata_o} !== {5'd9, 32'h55}) begin
            n_fail++;
            $display("FAIL load_next_capture: got wa=%0d wd=%h want 9 00000055", reg_waddr_o, reg_wdata_o);
        end
    endtask

    task automatic test_store();
        drive_idle();
        ex_valid = 1; reg_wdata = 32'h77; mem_req = 1; mem_we = 1;
        mem_addr = 32'h200; mem_wdata = 32'hA5A5A5A5;
        tick();
        drive_idle();
        n_cmp++;
        if ({mem_req_o, mem_we_o, mem_wdata_o, reg_wdata_o} !== {1'b1, 1'b1, 32'hA5A5A5A5, 32'h77}) begin
            n_fail++;
            $display("FAIL store_issue: got req=%b we=%b md=%h wd=%h want 1 1 a5a5a5a5 00000077",
                     mem_req_o, mem_we_o, mem_wdata_o, reg_wdata_o);
        end
        mem_ack = 1; mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ack = 0;
        n_cmp++;
        if ({mem_req_o, hold_req_o, reg_wdata_o} !== {1'b0, 1'b0, 32'h77}) begin
            n_fail++;
            $display("FAIL store_done: got req=%b hold=%b wd=%h want 0 0 00000077",
                     mem_req_o, hold_req_o, reg_wdata_o);
        end
    endtask

    task automatic test_hold_flush();
        drive_idle();
        ex_valid = 1; jump_flag = 1; jump_addr = 32'h800; reg_wdata = 32'h31;
        tick();
        hold_flag = 3; flush = 1; jump_addr = 32'h900; reg_wdata = 32'h32;
        tick();
        n_cmp++;
        if ({valid_o, jump_flag_o, jump_addr_o, reg_wdata_o} !== {1'b1, 1'b1, 32'h800, 32'h31}) begin
            n_fail++;
            $display("FAIL hold_beats_flush: got v=%b jf=%b ja=%h wd=%h want 1 1 00000800 00000031",
                     valid_o, jump_flag_o, jump_addr_o, reg_wdata_o);
        end
        hold_flag = 2;
        tick();
        n_cmp++;
        if ({valid_o, jump_flag_o, jump_addr_o, reg_wdata_o} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_bubble: got v=%b jf=%b ja=%h wd=%h want 0 0 0 0",
                     valid_o, jump_flag_o, jump_addr_o, reg_wdata_o);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_access();
        drive_idle();
        ex_valid = 1; mem_req = 1; mem_we = 0; mem_addr = 32'h300;
        tick();
        drive_idle();
        n_cmp++;
        if (mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_enter: got req=%b want 1", mem_req_o);
        end
        rst = 0;
        tick();
        rst = 1; mem_ack = 1; mem_rdata = 32'hCAFE;
        tick();
        mem_ack = 0;
        n_cmp++;
        if ({mem_req_o, hold_req_o, reg_wdata_o, valid_o} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_ack_ignored: got req=%b hold=%b wd=%h v=%b want 0 0 0 0",
                     mem_req_o, hold_req_o, reg_wdata_o, valid_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) >= 3);
            hold_flag = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            flush     = ($urandom_range(0, 4) == 0);
            ex_valid  = ($urandom_range(0, 9) < 7);
            reg_we    = $urandom_range(0, 1);
            reg_waddr = 5'($urandom_range(0, 3));
            reg_wdata = $urandom;
            mem_req   = ($urandom_range(0, 9) < 3);
            mem_we    = $urandom_range(0, 1);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            jump_flag = $urandom_range(0, 1);
            jump_addr = $urandom;
            id_raddr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            mem_ack   = ($urandom_range(0, 9) < 3);
            mem_rdata = $urandom;
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        rst = 1;
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load();
        test_store();
        test_hold_flush();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
